// File: rtl/memval_block_stats_if.sv
// rtl/memval_block_stats_if.sv - block-read word stream and statistics result bundle
//
// Purpose: groups the word stream, the block-read strobe and the result handshake
// of memval_block_stats into one bundle.
//   slave  : the statistics block (consumes words, drives the result)
//   master : the environment (multiplier side plus result consumer)
// Signals:
//   EN_blockRead  starts a block (same strobe the multiplier receives)
//   VALID_memVal  word strobe, memVal_data word payload
//   RDY_stats     block idle, VALID_stats result held
//   EN_statsAck   consumer takes the result
//   stats_sum/min/max/count/partial  result fields, overrun sticky error

interface memval_block_stats_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
);
    logic                     EN_blockRead;
    logic                     VALID_memVal;
    logic [DATA_W-1:0]        memVal_data;
    logic                     RDY_stats;
    logic                     VALID_stats;
    logic                     EN_statsAck;
    logic [DATA_W+ADDR_W-1:0] stats_sum;
    logic [DATA_W-1:0]        stats_min;
    logic [DATA_W-1:0]        stats_max;
    logic [ADDR_W:0]          stats_count;
    logic                     stats_partial;
    logic                     overrun;

    modport slave (
        input  EN_blockRead, VALID_memVal, memVal_data, EN_statsAck,
        output RDY_stats, VALID_stats, stats_sum, stats_min, stats_max,
               stats_count, stats_partial, overrun
    );

    modport master (
        output EN_blockRead, VALID_memVal, memVal_data, EN_statsAck,
        input  RDY_stats, VALID_stats, stats_sum, stats_min, stats_max,
               stats_count, stats_partial, overrun
    );
endinterface

// File: rtl/memval_block_stats.sv
// rtl/memval_block_stats.sv - per-block sum/min/max/count reducer for the block-read word stream
//
// Purpose: after each EN_blockRead, accumulates the words of one memory block and
// presents sum, minimum, maximum and count behind a valid/ack handshake. A block
// ends when BLOCK_LEN words are accepted or after TIMEOUT consecutive idle cycles
// (partial result). A block-read request while busy raises the sticky overrun flag.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  memval_block_stats_if slave modport (stream in, result out)

module memval_block_stats #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 6,
    parameter int BLOCK_LEN = 64,
    parameter int TIMEOUT   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    memval_block_stats_if.slave   bus
);

    localparam int SUM_W = DATA_W + ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t state_q, state_d;

    // working accumulators for the block in progress
    logic [SUM_W-1:0]  acc_sum_q, acc_sum_d;
    logic [DATA_W-1:0] acc_min_q, acc_min_d;
    logic [DATA_W-1:0] acc_max_q, acc_max_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [TMR_W-1:0]  idle_tmr_q, idle_tmr_d;

    // published result
    logic [SUM_W-1:0]  stats_sum_q, stats_sum_d;
    logic [DATA_W-1:0] stats_min_q, stats_min_d;
    logic [DATA_W-1:0] stats_max_q, stats_max_d;
    logic [CNT_W-1:0]  stats_count_q, stats_count_d;
    logic              stats_partial_q, stats_partial_d;
    logic              overrun_q, overrun_d;

    logic              clear_work;
    logic              load_stats;
    logic              load_partial;

    always_comb begin
        state_d         = state_q;
        acc_sum_d       = acc_sum_q;
        acc_min_d       = acc_min_q;
        acc_max_d       = acc_max_q;
        acc_cnt_d       = acc_cnt_q;
        idle_tmr_d      = idle_tmr_q;
        stats_sum_d     = stats_sum_q;
        stats_min_d     = stats_min_q;
        stats_max_d     = stats_max_q;
        stats_count_d   = stats_count_q;
        stats_partial_d = stats_partial_q;
        overrun_d       = overrun_q;
        clear_work      = 1'b0;
        load_stats      = 1'b0;
        load_partial    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.EN_blockRead) begin
                    clear_work = 1'b1;
                    state_d    = COLLECT;
                end
            end

            COLLECT: begin
                if (bus.EN_blockRead) begin
                    // restart wins over any word presented in the same cycle
                    clear_work = 1'b1;
                    overrun_d  = 1'b1;
                end else if (bus.VALID_memVal) begin
                    acc_sum_d  = acc_sum_q + SUM_W'(bus.memVal_data);
                    acc_min_d  = (bus.memVal_data < acc_min_q) ? bus.memVal_data : acc_min_q;
                    acc_max_d  = (bus.memVal_data > acc_max_q) ? bus.memVal_data : acc_max_q;
                    acc_cnt_d  = acc_cnt_q + CNT_W'(1);
                    idle_tmr_d = '0;
                    if (acc_cnt_q == CNT_W'(BLOCK_LEN - 1)) begin
                        load_stats = 1'b1;
                        state_d    = HOLD;
                    end
                end else if (idle_tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    // this is the TIMEOUT-th consecutive idle cycle
                    load_stats   = 1'b1;
                    load_partial = 1'b1;
                    state_d      = HOLD;
                end else begin
                    idle_tmr_d = idle_tmr_q + TMR_W'(1);
                end
            end

            HOLD: begin
                if (bus.EN_statsAck && bus.EN_blockRead) begin
                    // result consumed and next block started in one step
                    clear_work = 1'b1;
                    state_d    = COLLECT;
                end else if (bus.EN_statsAck) begin
                    state_d = IDLE;
                end else if (bus.EN_blockRead) begin
                    overrun_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        if (clear_work) begin
            acc_sum_d  = '0;
            acc_min_d  = '1;
            acc_max_d  = '0;
            acc_cnt_d  = '0;
            idle_tmr_d = '0;
        end

        // the _d values already include a word accepted in the closing cycle
        if (load_stats) begin
            stats_sum_d     = acc_sum_d;
            stats_min_d     = (acc_cnt_d == '0) ? '0 : acc_min_d;
            stats_max_d     = acc_max_d;
            stats_count_d   = acc_cnt_d;
            stats_partial_d = load_partial;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= IDLE;
            acc_sum_q       <= '0;
            acc_min_q       <= '0;
            acc_max_q       <= '0;
            acc_cnt_q       <= '0;
            idle_tmr_q      <= '0;
            stats_sum_q     <= '0;
            stats_min_q     <= '0;
            stats_max_q     <= '0;
            stats_count_q   <= '0;
            stats_partial_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            acc_sum_q       <= acc_sum_d;
            acc_min_q       <= acc_min_d;
            acc_max_q       <= acc_max_d;
            acc_cnt_q       <= acc_cnt_d;
            idle_tmr_q      <= idle_tmr_d;
            stats_sum_q     <= stats_sum_d;
            stats_min_q     <= stats_min_d;
            stats_max_q     <= stats_max_d;
            stats_count_q   <= stats_count_d;
            stats_partial_q <= stats_partial_d;
            overrun_q       <= overrun_d;
        end
    end

    // ready is held low for as long as reset is asserted
    assign bus.RDY_stats     = rst && (state_q == IDLE);
    assign bus.VALID_stats   = (state_q == HOLD);
    assign bus.stats_sum     = stats_sum_q;
    assign bus.stats_min     = stats_min_q;
    assign bus.stats_max     = stats_max_q;
    assign bus.stats_count   = stats_count_q;
    assign bus.stats_partial = stats_partial_q;
    assign bus.overrun       = overrun_q;

endmodule

// File: tb/tb_memval_block_stats.sv
// tb/tb_memval_block_stats.sv - self-checking bench for memval_block_stats

module tb_memval_block_stats;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 6;
    localparam int BLOCK_LEN = 64;
    localparam int TIMEOUT   = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    memval_block_stats_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    memval_block_stats #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BLOCK_LEN(BLOCK_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: the block is a list of accepted words, the result is
    // computed from that list when the block closes
    int unsigned words[$];
    bit          m_collect, m_hold, m_overrun, m_part;
    int          m_idle;
    longint      m_sum, m_min, m_max, m_cnt;

    task automatic model_start();
        words.delete();
        m_idle    = 0;
        m_collect = 1'b1;
        m_hold    = 1'b0;
    endtask

    task automatic model_close(input bit partial);
        m_sum = 0;
        m_min = 65535;
        m_max = 0;
        foreach (words[i]) begin
            m_sum += words[i];
            if (words[i] < m_min) m_min = words[i];
            if (words[i] > m_max) m_max = words[i];
        end
        m_cnt = words.size();
        if (m_cnt == 0) m_min = 0;
        m_part    = partial;
        m_collect = 1'b0;
        m_hold    = 1'b1;
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            words.delete();
            m_collect = 0; m_hold = 0; m_overrun = 0; m_part = 0; m_idle = 0;
            m_sum = 0; m_min = 0; m_max = 0; m_cnt = 0;
        end else if (m_collect) begin
            if (bus.EN_blockRead) begin
                words.delete();
                m_idle    = 0;
                m_overrun = 1'b1;
            end else if (bus.VALID_memVal) begin
                words.push_back(bus.memVal_data);
                m_idle = 0;
                if (words.size() == BLOCK_LEN) model_close(1'b0);
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT) model_close(1'b1);
            end
        end else if (m_hold) begin
            if (bus.EN_statsAck && bus.EN_blockRead) model_start();
            else if (bus.EN_statsAck) m_hold = 1'b0;
            else if (bus.EN_blockRead) m_overrun = 1'b1;
        end else if (bus.EN_blockRead) begin
            model_start();
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("rdy",     bus.RDY_stats,     rst && !m_collect && !m_hold);
            chk("valid",   bus.VALID_stats,   m_hold);
            chk("sum",     bus.stats_sum,     m_sum);
            chk("min",     bus.stats_min,     m_min);
            chk("max",     bus.stats_max,     m_max);
            chk("count",   bus.stats_count,   m_cnt);
            chk("partial", bus.stats_partial, m_part);
            chk("overrun", bus.overrun,       m_overrun);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_en();
        bus.EN_blockRead = 1'b1;
        step();
        bus.EN_blockRead = 1'b0;
    endtask

    task automatic ack();
        bus.EN_statsAck = 1'b1;
        step();
        bus.EN_statsAck = 1'b0;
    endtask

    task automatic send_word(input int unsigned v);
        bus.VALID_memVal = 1'b1;
        bus.memVal_data  = v[DATA_W-1:0];
        step();
        bus.VALID_memVal = 1'b0;
    endtask

    initial begin
        int n;
        bus.EN_blockRead = 1'b0;
        bus.VALID_memVal = 1'b0;
        bus.memVal_data  = '0;
        bus.EN_statsAck  = 1'b0;

        step();
        cmp_on = 1'b1;
        step();
        chk("reset_rdy",   bus.RDY_stats, 0);
        chk("reset_valid", bus.VALID_stats, 0);
        chk("reset_sum",   bus.stats_sum, 0);
        rst = 1'b1;
        step();
        chk("release_rdy", bus.RDY_stats, 1);

        // full block of k*k, back to back
        pulse_en();
        for (int k = 0; k < 64; k++) begin
            if (k == 63) chk("t1_not_early", bus.VALID_stats, 0);
            send_word(k * k);
        end
        chk("t1_valid",       bus.VALID_stats, 1);
        chk("t1_model_sum",   m_sum, 85344);
        chk("t1_sum",         bus.stats_sum, 85344);
        chk("t1_min",         bus.stats_min, 0);
        chk("t1_max",         bus.stats_max, 3969);
        chk("t1_count",       bus.stats_count, 64);
        chk("t1_partial",     bus.stats_partial, 0);
        chk("t1_overrun",     bus.overrun, 0);
        ack();
        chk("t1_rdy_after_ack", bus.RDY_stats, 1);

        // same block with one idle cycle between words
        pulse_en();
        for (int k = 0; k < 64; k++) begin
            send_word(k * k);
            if (k != 63) step();
        end
        chk("t2_valid",   bus.VALID_stats, 1);
        chk("t2_sum",     bus.stats_sum, 85344);
        chk("t2_max",     bus.stats_max, 3969);
        chk("t2_count",   bus.stats_count, 64);
        chk("t2_partial", bus.stats_partial, 0);

        // ack and new request together: straight into collecting
        bus.EN_statsAck  = 1'b1;
        bus.EN_blockRead = 1'b1;
        step();
        bus.EN_statsAck  = 1'b0;
        bus.EN_blockRead = 1'b0;
        chk("hs_rdy",     bus.RDY_stats, 0);
        chk("hs_valid",   bus.VALID_stats, 0);
        chk("hs_overrun", bus.overrun, 0);

        // ten 0xFFFF words then stall into timeout
        for (int k = 0; k < 10; k++) send_word(16'hFFFF);
        n = 0;
        while (!bus.VALID_stats && n < 40) begin
            step();
            n++;
        end
        chk("t3_idle_cycles", n, 16);
        chk("t3_model_sum",   m_sum, 655350);
        chk("t3_sum",         bus.stats_sum, 655350);
        chk("t3_min",         bus.stats_min, 16'hFFFF);
        chk("t3_max",         bus.stats_max, 16'hFFFF);
        chk("t3_count",       bus.stats_count, 10);
        chk("t3_partial",     bus.stats_partial, 1);
        ack();
        chk("t3_rdy", bus.RDY_stats, 1);

        // empty block: timeout with no words gives zeros
        pulse_en();
        for (int k = 0; k < TIMEOUT; k++) step();
        chk("t0_valid",   bus.VALID_stats, 1);
        chk("t0_count",   bus.stats_count, 0);
        chk("t0_min",     bus.stats_min, 0);
        chk("t0_partial", bus.stats_partial, 1);
        ack();

        // restart mid-block, word in the restart cycle is discarded
        pulse_en();
        for (int k = 0; k < 5; k++) send_word(100 + k);
        bus.EN_blockRead = 1'b1;
        bus.VALID_memVal = 1'b1;
        bus.memVal_data  = 16'h1234;
        step();
        bus.EN_blockRead = 1'b0;
        bus.VALID_memVal = 1'b0;
        for (int k = 0; k < 64; k++) send_word(1);
        chk("t4_sum",     bus.stats_sum, 64);
        chk("t4_count",   bus.stats_count, 64);
        chk("t4_min",     bus.stats_min, 1);
        chk("t4_max",     bus.stats_max, 1);
        chk("t4_overrun", bus.overrun, 1);
        pulse_en();
        chk("t4_hold_valid", bus.VALID_stats, 1);
        chk("t4_hold_sum",   bus.stats_sum, 64);
        ack();
        chk("t4_rdy", bus.RDY_stats, 1);

        // words in idle are ignored, then reset mid-collect
        for (int k = 0; k < 3; k++) send_word(99);
        chk("idle_rdy", bus.RDY_stats, 1);
        chk("idle_sum", bus.stats_sum, 64);
        pulse_en();
        for (int k = 0; k < 7; k++) send_word(7);
        rst = 1'b0;
        bus.VALID_memVal = 1'b1;
        step();
        step();
        bus.VALID_memVal = 1'b0;
        chk("rst_rdy",     bus.RDY_stats, 0);
        chk("rst_valid",   bus.VALID_stats, 0);
        chk("rst_sum",     bus.stats_sum, 0);
        chk("rst_count",   bus.stats_count, 0);
        chk("rst_overrun", bus.overrun, 0);
        rst = 1'b1;
        step();
        chk("rst_release_rdy", bus.RDY_stats, 1);

        // randomized blocks against the model
        for (int blk = 0; blk < 40; blk++) begin
            bit stall;
            int stall_at, sent;
            stall    = ($urandom_range(0, 2) == 0);
            stall_at = $urandom_range(0, BLOCK_LEN - 1);
            sent     = 0;
            for (int k = $urandom_range(0, 3); k > 0; k--) begin
                bus.VALID_memVal = $urandom_range(0, 1);
                bus.memVal_data  = DATA_W'($urandom_range(0, 65535));
                step();
            end
            bus.VALID_memVal = 1'b0;
            pulse_en();
            n = 0;
            while (!m_hold && n < 3000) begin
                if (stall && sent >= stall_at) bus.VALID_memVal = 1'b0;
                else bus.VALID_memVal = ($urandom_range(0, 99) < 70);
                bus.memVal_data  = DATA_W'($urandom_range(0, 65535));
                bus.EN_blockRead = ($urandom_range(0, 199) == 0);
                if (bus.VALID_memVal) sent++;
                step();
                n++;
            end
            bus.VALID_memVal = 1'b0;
            bus.EN_blockRead = 1'b0;
            chk("rand_block_done", m_hold, 1);
            case ($urandom_range(0, 3))
                0: begin
                    pulse_en();
                    ack();
                end
                1: begin
                    bus.EN_statsAck  = 1'b1;
                    bus.EN_blockRead = 1'b1;
                    step();
                    bus.EN_statsAck  = 1'b0;
                    bus.EN_blockRead = 1'b0;
                    n = 0;
                    while (!m_hold && n < 200) begin
                        step();
                        n++;
                    end
                    ack();
                end
                default: ack();
            endcase
        end

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memval_block_stats.md
Name: memval_block_stats

Overview:
- Sits directly downstream of the multiplier's block-read port and consumes the VALID_memVal/memVal_data word stream that follows each EN_blockRead.
- Reduces one memory block (nominally 64 words of 16 bits) to a sum, minimum, maximum and word count.
- Holds the result behind a valid/ack handshake until the consumer takes it.
- Detects short (stalled) blocks with a timeout, and flags block-read requests that arrive while it is busy.

Parameters:
- DATA_W, 16, width of memVal_data.
- ADDR_W, 6, memory address width; the block holds 2**ADDR_W words.
- BLOCK_LEN, 64, number of words in a full block (must be ≤ 2**ADDR_W).
- TIMEOUT, 16, consecutive no-valid cycles in COLLECT that end a block early.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- EN_blockRead  in  1  same strobe the multiplier receives; starts a block.
- VALID_memVal  in  1  word strobe from the multiplier.
- memVal_data  in  DATA_W  word data, sampled when VALID_memVal=1.
- RDY_stats  out  1  block is idle and can accept a new EN_blockRead.
- VALID_stats  out  1  result registers hold a completed block.
- EN_statsAck  in  1  consumer takes the result; only meaningful while VALID_stats=1.
- stats_sum  out  DATA_W+ADDR_W  sum of the accepted words (22 bits at defaults).
- stats_min  out  DATA_W  minimum accepted word; 0 if stats_count=0.
- stats_max  out  DATA_W  maximum accepted word; 0 if stats_count=0.
- stats_count  out  ADDR_W+1  number of words accepted.
- stats_partial  out  1  block ended by timeout, not by reaching BLOCK_LEN.
- overrun  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (rst=0 on a clk edge):
  - State goes to IDLE.
  - Every output register clears to 0: stats_*, VALID_stats, overrun.
  - RDY_stats=0 while rst=0, and 1 from the first cycle after release.
- States: IDLE, COLLECT, HOLD. RDY_stats=(state==IDLE); VALID_stats=(state==HOLD).
- Working registers: acc_sum, acc_min, acc_max, acc_cnt, idle_tmr.
  - Cleared on block start to: acc_sum=0, acc_min=all-ones, acc_max=0, acc_cnt=0, idle_tmr=0.
- IDLE:
  - EN_blockRead=1 clears the working registers; next state is COLLECT.
  - VALID_memVal is ignored.
- COLLECT, VALID_memVal=1:
  - acc_sum+=memVal_data (zero-extended, never overflows), acc_min=min, acc_max=max, acc_cnt++, idle_tmr=0.
  - If this is word BLOCK_LEN (acc_cnt==BLOCK_LEN-1 before the update), go to HOLD with partial=0.
- COLLECT, VALID_memVal=0:
  - idle_tmr++.
  - When idle_tmr reaches TIMEOUT-1 on a no-valid cycle (the TIMEOUTth consecutive idle cycle), go to HOLD with partial=1.
- COLLECT, EN_blockRead=1:
  - Restart: working registers clear, overrun<=1, state stays COLLECT.
  - A VALID_memVal word in that same cycle is discarded.
- Entry to HOLD:
  - stats_* load from the final working values, including the word accepted in the transition cycle.
  - stats_min is forced to 0 when count=0.
  - Latency: the last word is accepted at edge N and VALID_stats=1 after edge N (visible in cycle N+1).
- HOLD:
  - stats_* stay stable; VALID_memVal is ignored.
  - EN_statsAck=1 alone: next state is IDLE.
  - EN_blockRead=1 without ack: overrun<=1, request dropped, result preserved.
  - EN_statsAck=1 and EN_blockRead=1 in the same cycle: go straight to COLLECT with cleared working registers; no overrun.
- stats_* keep their last loaded value through IDLE and COLLECT until the next HOLD entry.
- Reset mid-COLLECT or mid-HOLD aborts everything; no partial result is produced.

Test Plan:
- Reset, EN_blockRead pulse, 64 back-to-back words memVal_data=k*k (k=0..63) -> VALID_stats one cycle after the 64th word; sum=85344, min=0, max=3969, count=64, partial=0, overrun=0.
- Same 64 words with one idle cycle between each word -> identical result; partial=0, since gaps are shorter than TIMEOUT.
- 10 words of 0xFFFF, then VALID_memVal held low -> VALID_stats after the 16th idle cycle; sum=655350, min=max=0xFFFF, count=10, partial=1.
- Restart and overrun case:
  - Mid-block after 5 words, EN_blockRead pulses again, then 64 words of value 1 -> sum=64, count=64, min=max=1, overrun=1.
  - Then EN_blockRead in HOLD without ack -> result unchanged, still VALID_stats=1.
- Handshake case:
  - In HOLD, EN_statsAck and EN_blockRead together -> next cycle RDY_stats=0, VALID_stats=0, COLLECT active, no new overrun.
  - Lone ack -> RDY_stats=1 next cycle.
- Words in IDLE are ignored; then rst=0 in mid-COLLECT -> all outputs 0, RDY_stats=1 one cycle after release.
